// File: rtl/button_conditioner.sv
// Front-panel button synchroniser, debouncer and press/release strobe generator.
// Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat press strobes.
module button_conditioner #(
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_conditioner: cycle parameters must be >= 1");
  end

  logic [N_BUTTONS-1:0] sync1;
  logic [N_BUTTONS-1:0] sync2;
  logic [CW-1:0]        cnt [N_BUTTONS];
  logic [N_BUTTONS-1:0] flip;
  logic [N_BUTTONS-1:0] rise;
  logic [N_BUTTONS-1:0] fall;

  always_comb begin
    flip = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      flip[i] = (sync2[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = flip & ~btn_level;
  assign fall = flip & btn_level;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_level <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_level <= btn_level ^ flip;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (sync2[i] == btn_level[i] || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]        rcnt [N_BUTTONS];
  logic [N_BUTTONS-1:0] rphase;
  logic [N_BUTTONS-1:0] rep_hit;

  // Repeat is suppressed on the falling edge so it never meets a release.
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      rep_hit[i] = btn_level[i] && !flip[i] &&
                   (rcnt[i] == (rphase[i] ? RP_LAST : RD_LAST));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rphase <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        rcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (!btn_level[i] || flip[i]) begin
          rcnt[i]   <= '0;
          rphase[i] <= 1'b0;
        end else if (rep_hit[i]) begin
          rcnt[i]   <= '0;
          rphase[i] <= 1'b1;
        end else begin
          rcnt[i]   <= rcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= rise | rep_hit;
      btn_release <= fall;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= rise;
      btn_release <= fall;
    end
  end
`endif

endmodule
